// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } i2c_slave_state_t;

    localparam logic       I2C_RW_READ  = 1'b1;
    localparam logic [6:0] I2C_GEN_CALL = 7'h00;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser for one open-drain bus line, optional glitch filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and single-cycle rise/fall detection.
// Flops reset to 1 because an idle I2C bus is pulled high.
module i2c_sync_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic line_q;
    logic line_dly;

    // Metastability guard on the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FILT_LEN - 1);

    logic [CNT_W-1:0] filt_cnt;
    logic             filt_q;

    // Down-counter: the filtered level follows only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= 1'b1;
            filt_cnt <= CNT_RELOAD;
        end else if (sync_2 == filt_q) begin
            filt_cnt <= CNT_RELOAD;
        end else if (filt_cnt == '0) begin
            filt_q   <= sync_2;
            filt_cnt <= CNT_RELOAD;
        end else begin
            filt_cnt <= filt_cnt - 1'b1;
        end
    end

    assign line_q = filt_q;
`else
    logic unused_filt_len;
    assign unused_filt_len = ^FILT_LEN;
    assign line_q = sync_2;
`endif

    // Previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_dly <= 1'b1;
        end else begin
            line_dly <= line_q;
        end
    end

    assign level = line_q;
    assign rise  = line_q & ~line_dly;
    assign fall  = ~line_q & line_dly;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target, no clock stretching, SDA driven open-drain via sda_oe_o.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
//
// state        | meaning
// ST_IDLE      | bus ignored until a START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | address matched, ACK driven for the 9th bit
// ST_WRITE     | shifting in a data byte from the master
// ST_WRITE_ACK | ACK driven for a received data byte
// ST_READ      | shifting out a data byte to the master
// ST_READ_ACK  | master ACK/NACK slot after a transmitted byte
// ST_WAIT_STOP | not addressed or NACKed; wait for STOP/START
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR     = 7'h42,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       busy_o,
    output logic       stop_o
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (scl_i),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sda_i),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;

    i2c_slave_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    // Only 7 bits are stored: the 8th received bit is taken straight from SDA,
    // and the MSB of a transmitted byte is driven straight from tx_data_i.
    logic [6:0] shreg_q, shreg_d;
    logic       sda_oe_q, sda_oe_d;
    logic       ack_hold_q, ack_hold_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_d, tx_req_d, busy_q, busy_d, stop_d;

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sda_oe_q   <= 1'b0;
            ack_hold_q <= 1'b0;
            rw_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;
            busy_q     <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sda_oe_q   <= sda_oe_d;
            ack_hold_q <= ack_hold_d;
            rw_q       <= rw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_o <= rx_valid_d;
            tx_req_o   <= tx_req_d;
            busy_q     <= busy_d;
            stop_o     <= stop_d;
        end
    end

    // Next-state logic; START/STOP override any bit processing.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sda_oe_d   = sda_oe_q;
        ack_hold_d = ack_hold_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        stop_d     = 1'b0;

        if (stop_det) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            ack_hold_d = 1'b0;
            busy_d     = 1'b0;
            stop_d     = 1'b1;
        end else if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            ack_hold_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shreg_q == ADDR && shreg_q != I2C_GEN_CALL) begin
                                state_d  = ST_ADDR_ACK;
                                busy_d   = 1'b1;
                                rw_d     = sda;
                                tx_req_d = (sda == I2C_RW_READ);
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // First SCL fall after the 8th bit pulls SDA low, the next one ends the ACK.
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_hold_q) begin
                            sda_oe_d   = 1'b1;
                            ack_hold_d = 1'b1;
                        end else begin
                            ack_hold_d = 1'b0;
                            bit_cnt_d  = '0;
                            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                                state_d  = ST_READ;
                                shreg_d  = tx_data_i[6:0];
                                sda_oe_d = ~tx_data_i[7];
                            end else begin
                                state_d  = ST_WRITE;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = {shreg_q, sda};
                            rx_valid_d = 1'b1;
                            state_d    = ST_WRITE_ACK;
                        end
                    end
                end
                ST_READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_READ_ACK;
                        end else begin
                            sda_oe_d = ~shreg_q[6];
                            shreg_d  = {shreg_q[5:0], 1'b0};
                        end
                    end
                end
                // Master ACK requests the next byte; it is loaded on the fall ending the ACK bit.
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            ack_hold_d = 1'b1;
                            tx_req_d   = 1'b1;
                        end
                    end else if (scl_fall && ack_hold_q) begin
                        ack_hold_d = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = ST_READ;
                        shreg_d    = tx_data_i[6:0];
                        sda_oe_d   = ~tx_data_i[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe_o  = sda_oe_q;
    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, open-drain SDA model, and a
// transaction-level reference (ack iff address 0x42, written bytes appear in
// order, read bytes come back as supplied).
module tb_i2c_slave;

    localparam logic [6:0] TGT = 7'h42;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_i = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_i;
    logic       sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_req_o;
    logic       busy_o;
    logic       stop_o;

    int total = 0;
    int bad = 0;
    int txreq_cnt = 0;
    int stop_cnt = 0;
    int oe_cnt = 0;
    int viol_cnt = 0;
    logic prev_oe = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    assign sda_i = m_sda & ~sda_oe_o;

    i2c_slave #(.ADDR(TGT), .FILT_LEN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_oe_o   (sda_oe_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .tx_data_i  (tx_data_i),
        .tx_req_o   (tx_req_o),
        .busy_o     (busy_o),
        .stop_o     (stop_o)
    );

    always #5 clk = ~clk;

    // Passive monitor: collects received bytes, serves read data, counts pulses.
    always @(negedge clk) begin
        if (rx_valid_o) rx_q.push_back(rx_data_o);
        if (tx_req_o) begin
            txreq_cnt++;
            if (tx_q.size() > 0) tx_data_i = tx_q.pop_front();
            else tx_data_i = 8'hFF;
        end
        if (stop_o) stop_cnt++;
        if (sda_oe_o) oe_cnt++;
        if (sda_oe_o !== prev_oe && scl_i) viol_cnt++;
        prev_oe = sda_oe_o;
    end

    task automatic wait_q();
        repeat (10) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        scl_i = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        scl_i = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        scl_i = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; wait_q();
        scl_i = 1'b1; wait_q(); wait_q();
        scl_i = 1'b0; wait_q();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wait_q();
        scl_i = 1'b1; wait_q();
        b = sda_i; wait_q();
        scl_i = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (sda_oe_o !== 1'b0)    begin bad++; $display("FAIL rst_sda_oe got=%b want=0", sda_oe_o); end
        total++; if (rx_data_o !== 8'h00)  begin bad++; $display("FAIL rst_rx_data got=%h want=00", rx_data_o); end
        total++; if (rx_valid_o !== 1'b0)  begin bad++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid_o); end
        total++; if (tx_req_o !== 1'b0)    begin bad++; $display("FAIL rst_tx_req got=%b want=0", tx_req_o); end
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        total++; if (stop_o !== 1'b0)      begin bad++; $display("FAIL rst_stop got=%b want=0", stop_o); end
        rst_n = 1'b1;
        wait_q();
    endtask

    task automatic test_write();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] exp_q[$];
            logic ack;
            int n, s0;
            n = (it == 0) ? 1 : int'($urandom_range(2, 4));
            for (int k = 0; k < n; k++) exp_q.push_back((it == 0) ? 8'h55 : 8'($urandom));
            rx_q.delete();
            s0 = stop_cnt;
            bus_start();
            send_byte({TGT, 1'b0}, ack);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_addr_ack it=%0d got=%b want=1", it, ack); end
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wr_busy it=%0d got=%b want=1", it, busy_o); end
            foreach (exp_q[k]) begin
                send_byte(exp_q[k], ack);
                total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_data_ack it=%0d byte=%0d got=%b want=1", it, k, ack); end
            end
            bus_stop();
            total++; if (rx_q.size() != n) begin bad++; $display("FAIL wr_rx_count it=%0d got=%0d want=%0d", it, rx_q.size(), n); end
            for (int k = 0; k < n && k < rx_q.size(); k++) begin
                total++; if (rx_q[k] !== exp_q[k]) begin bad++; $display("FAIL wr_rx_byte it=%0d k=%0d got=%h want=%h", it, k, rx_q[k], exp_q[k]); end
            end
            total++; if (rx_data_o !== exp_q[n-1]) begin bad++; $display("FAIL wr_rx_data it=%0d got=%h want=%h", it, rx_data_o, exp_q[n-1]); end
            total++; if (stop_cnt - s0 != 1) begin bad++; $display("FAIL wr_stop it=%0d got=%0d want=1", it, stop_cnt - s0); end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wr_busy_end it=%0d got=%b want=0", it, busy_o); end
        end
    endtask

    task automatic test_mismatch();
        for (int it = 0; it < 3; it++) begin
            logic [6:0] a;
            logic ack;
            int oe0;
            if (it == 0) a = 7'h43;
            else if (it == 1) a = 7'h00;
            else begin
                a = 7'($urandom);
                while (a == TGT) a = 7'($urandom);
            end
            rx_q.delete();
            oe0 = oe_cnt;
            bus_start();
            send_byte({a, 1'b0}, ack);
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_addr_ack a=%h got=%b want=0", a, ack); end
            send_byte(8'hFF, ack);
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_data_ack a=%h got=%b want=0", a, ack); end
            bus_stop();
            total++; if (oe_cnt != oe0) begin bad++; $display("FAIL mm_sda_oe a=%h got=%0d cycles want=0", a, oe_cnt - oe0); end
            total++; if (rx_q.size() != 0) begin bad++; $display("FAIL mm_rx_valid a=%h got=%0d want=0", a, rx_q.size()); end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mm_busy a=%h got=%b want=0", a, busy_o); end
        end
    endtask

    task automatic test_read();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] exp_q[$];
            logic [7:0] got;
            logic ack;
            int n, t0;
            if (it == 0) begin
                exp_q.push_back(8'hA5);
                exp_q.push_back(8'h3C);
            end else begin
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) exp_q.push_back(8'($urandom));
            end
            n = exp_q.size();
            foreach (exp_q[k]) tx_q.push_back(exp_q[k]);
            t0 = txreq_cnt;
            bus_start();
            send_byte({TGT, 1'b1}, ack);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL rd_addr_ack it=%0d got=%b want=1", it, ack); end
            for (int k = 0; k < n; k++) begin
                recv_byte(k == n - 1, got);
                total++; if (got !== exp_q[k]) begin bad++; $display("FAIL rd_byte it=%0d k=%0d got=%h want=%h", it, k, got, exp_q[k]); end
            end
            total++; if (sda_oe_o !== 1'b0) begin bad++; $display("FAIL rd_release it=%0d got=%b want=0", it, sda_oe_o); end
            total++; if (txreq_cnt - t0 != n) begin bad++; $display("FAIL rd_tx_req it=%0d got=%0d want=%0d", it, txreq_cnt - t0, n); end
            bus_stop();
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rd_busy_end it=%0d got=%b want=0", it, busy_o); end
        end
    endtask

    task automatic test_repeated_start();
        for (int it = 0; it < 2; it++) begin
            logic [7:0] d, r, got;
            logic ack;
            int s0;
            d = (it == 0) ? 8'h10 : 8'($urandom);
            r = 8'($urandom);
            s0 = stop_cnt;
            bus_start();
            send_byte({TGT, 1'b0}, ack);
            send_byte(d, ack);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL rs_wr_ack it=%0d got=%b want=1", it, ack); end
            total++; if (rx_data_o !== d) begin bad++; $display("FAIL rs_rx_data it=%0d got=%h want=%h", it, rx_data_o, d); end
            bus_start();
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rs_busy it=%0d got=%b want=1", it, busy_o); end
            tx_q.push_back(r);
            send_byte({TGT, 1'b1}, ack);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL rs_rd_ack it=%0d got=%b want=1", it, ack); end
            recv_byte(1'b1, got);
            total++; if (got !== r) begin bad++; $display("FAIL rs_rd_byte it=%0d got=%h want=%h", it, got, r); end
            bus_stop();
            total++; if (stop_cnt - s0 != 1) begin bad++; $display("FAIL rs_stop it=%0d got=%0d want=1", it, stop_cnt - s0); end
        end
    endtask

    task automatic test_reset_mid();
        logic ack, b;
        logic [7:0] d;
        int rx0;
        // reset after 4 data bits of a write
        bus_start();
        send_byte({TGT, 1'b0}, ack);
        for (int i = 7; i >= 4; i--) put_bit(1'b1);
        rx_q.delete();
        rst_n = 1'b0;
        #1;
        total++; if (sda_oe_o !== 1'b0) begin bad++; $display("FAIL rm_oe_data got=%b want=0", sda_oe_o); end
        wait_q();
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) put_bit(1'b0);
        get_bit(b);
        total++; if (b !== 1'b1) begin bad++; $display("FAIL rm_ignored_ack got=%b want=1", b); end
        bus_stop();
        rx0 = rx_q.size();
        total++; if (rx0 != 0) begin bad++; $display("FAIL rm_rx_valid got=%0d want=0", rx0); end
        // reset while the ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(((i == 7) || (i == 2)) ? 1'b1 : 1'b0);
        total++; if (sda_oe_o !== 1'b1) begin bad++; $display("FAIL rm_ack_driven got=%b want=1", sda_oe_o); end
        rst_n = 1'b0;
        #1;
        total++; if (sda_oe_o !== 1'b0) begin bad++; $display("FAIL rm_async_release got=%b want=0", sda_oe_o); end
        wait_q();
        rst_n = 1'b1;
        get_bit(b);
        bus_stop();
        // a complete transaction afterwards
        d = 8'($urandom);
        rx_q.delete();
        bus_start();
        send_byte({TGT, 1'b0}, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rm_next_ack got=%b want=1", ack); end
        send_byte(d, ack);
        bus_stop();
        total++; if (rx_q.size() != 1 || rx_data_o !== d) begin bad++; $display("FAIL rm_next_rx got=%h n=%0d want=%h n=1", rx_data_o, rx_q.size(), d); end
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic ack;
        logic [7:0] d;
        d = 8'($urandom);
        rx_q.delete();
        bus_start();
        send_byte({TGT, 1'b0}, ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = d[i]; wait_q();
            scl_i = 1'b1;
            repeat (8) @(posedge clk); #2;
            scl_i = 1'b0;
            @(posedge clk); #2;
            scl_i = 1'b1;
            repeat (11) @(posedge clk); #2;
            scl_i = 1'b0; wait_q();
        end
        begin
            logic b;
            get_bit(b);
            ack = ~b;
        end
        bus_stop();
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL gl_ack got=%b want=1", ack); end
        total++; if (rx_q.size() != 1 || rx_data_o !== d) begin bad++; $display("FAIL gl_rx got=%h n=%0d want=%h n=1", rx_data_o, rx_q.size(), d); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_reset_mid();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch();
`endif
        total++; if (viol_cnt != 0) begin bad++; $display("FAIL sda_change_scl_high got=%0d want=0", viol_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C target (slave) that responds to transactions generated by `i2c_master`, so the two can run back-to-back on one bus. It oversamples SCL and SDA in the system clock domain, detects START and STOP conditions, and matches a 7-bit address. It returns ACKs, delivers written bytes to user logic, and serialises bytes supplied by user logic on reads. SDA is driven open-drain through an output-enable; the block never drives SCL (no clock stretching).

## Interface
- `ADDR`, default `7'h42`: 7-bit target address.
- `FILT_LEN`, default `3`: glitch-filter depth in clk cycles. Used only when the filter is compiled in.

- `clk` in 1: system clock; must be ≥ 20× SCL frequency.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `scl_i` in 1: raw SCL pin level (asynchronous).
- `sda_i` in 1: raw SDA pin level (asynchronous).
- `sda_oe_o` out 1: 1 = pull SDA low; 0 = release.
- `rx_data_o` out 8: last byte written by the master.
- `rx_valid_o` out 1: one-cycle pulse when `rx_data_o` updates.
- `tx_data_i` in 8: next byte to return on a read.
- `tx_req_o` out 1: one-cycle pulse requesting the next `tx_data_i`.
- `busy_o` out 1: high from an addressed START until STOP.
- `stop_o` out 1: one-cycle pulse on every detected STOP.

## Operation
- **Input conditioning.** Both inputs pass through a 2-flop synchroniser. A registered copy gives rise/fall detect.
- **Bus conditions.**
  - START/repeated START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognised in every state and take priority over bit processing.
- **States:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- **Transitions:**
  - START → ADDR from any state. Clears the bit counter and releases SDA.
  - STOP → IDLE from any state. Releases SDA and pulses `stop_o`.
  - ADDR: shift SDA MSB-first on each SCL rise. After 8 bits:
    - Address match → ADDR_ACK; assert `busy_o`.
    - Mismatch, including general call 0x00 → WAIT_STOP, no ACK.
  - ADDR_ACK: drive SDA low for the 9th bit.
    - R/W = 0 → WRITE.
    - R/W = 1 → READ; `tx_req_o` pulses on entry to ADDR_ACK.
  - WRITE: after 8 bits, load `rx_data_o`, pulse `rx_valid_o`, → WRITE_ACK. Every byte is ACKed.
  - WRITE_ACK → WRITE, for unlimited bytes.
  - READ: load `tx_data_i` into the shift register on the SCL fall that ends the ACK bit. Drive each bit (`sda_oe_o` = ~bit); release SDA after bit 0.
  - READ_ACK: sample SDA on SCL rise.
    - 0 (master ACK) → READ and pulse `tx_req_o`.
    - 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released; waits for STOP or START.
- **Bit counter.** 4 bits, counts 0–8, cleared on START and at each ACK-phase exit.
- **Reset mid-transfer.** Immediate IDLE; SDA released asynchronously. The block ignores the bus until the next START, so a partial byte is never reported.

## Timing
- **Output reset values:** `sda_oe_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `tx_req_o`=0, `busy_o`=0, `stop_o`=0.
- **Detect latency:** pin edge → internal edge pulse is 3 clk, plus `FILT_LEN` when the filter is compiled in.
- **SDA changes:** only 1 clk after a detected SCL fall. This guarantees hold time while SCL is low.
- **SDA sampling:** on the detected SCL rise.
- **`rx_valid_o`:** 1 clk after the 8th data-bit SCL rise.
- **`tx_req_o` → `tx_data_i` sampling:** at least one half SCL period. User logic must hold `tx_data_i` stable from `tx_req_o` until the next SCL fall.
- **`busy_o`:** rises 1 clk after the address match; falls 1 clk after STOP detect.

## Configuration
- Macro `I2C_SLAVE_GLITCH_FILTER_EN`.
- **Defined:** after the synchroniser, each line passes a `FILT_LEN`-deep majority/stable filter. Pulses shorter than `FILT_LEN` clk are rejected.
- **Undefined:** synchroniser only; any 1-clk pulse is treated as an edge.

## Structure
- Shared package `i2c_pkg`:
  - state enum `i2c_slave_state_t`;
  - constant `I2C_RW_READ = 1'b1`;
  - constant `I2C_GEN_CALL = 7'h00`.
- One sub-module, `i2c_sync_filter` (synchroniser, optional filter, rise/fall outputs), instantiated once per line.

## Test plan
- **Write:** START, byte 0x84, byte 0x55, STOP → ACK on both 9th bits; `rx_data_o`=0x55; exactly one `rx_valid_o` pulse; `stop_o` pulses; `busy_o` back to 0.
- **Address mismatch:** START, byte 0x86, byte 0xFF, STOP → `sda_oe_o` stays 0 throughout; no `rx_valid_o`.
- **Read:**
  - Stimulus: START, byte 0x85, `tx_data_i`=0xA5, master ACK, then `tx_data_i`=0x3C, master NACK, STOP.
  - Required response: SDA bits 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0; two `tx_req_o` pulses; SDA released after the NACK.
- **Repeated START:** write 0x84/0x10, then repeated START, 0x85 with no STOP → `rx_data_o`=0x10, then read proceeds; `busy_o` stays high across the repeated START.
- **Reset mid-byte:** `rst_n` low after 4 data bits of a write → `sda_oe_o`=0 in the same cycle; no `rx_valid_o`; the next full transaction succeeds.
- **Glitch, macro defined, `FILT_LEN`=3:** 1-clk SCL low pulse mid-bit → no extra bit shifted; `rx_data_o` correct.
